// File: rtl/stream_tx_arbiter.sv
// Packet-atomic round-robin arbiter that merges N_REQ requester streams
// onto one registered NAP transmit stream.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no owner; pick the next valid requester after last_winner
// ST_OWNED | grant held by owner until its eop beat is accepted
module stream_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 4,
  parameter int MAX_BEATS = 64
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0]          req_sop,
  input  logic [N_REQ-1:0]          req_eop,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic [ADDR_W-1:0]         tx_addr,
  output logic                      tx_sop,
  output logic                      tx_eop,
  output logic [N_REQ-1:0]          grant,
  output logic [15:0]               pkt_count,
  output logic                      sop_err,
  output logic                      len_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BEATS + 2);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  logic [0:0]        state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  last_winner;
  logic [CNT_W-1:0]  beat_cnt;

  logic              load;
  logic              beat_acc;
  logic [IDX_W-1:0]  next_win;
  logic [IDX_W-1:0]  scan_idx;
  logic              found;

  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_sop;
  logic              sel_eop;

  assign load      = !tx_valid | tx_ready;
  assign req_ready = grant & {N_REQ{load}};
  assign beat_acc  = (state == ST_OWNED) & req_valid[owner] & load;

  assign sel_data = req_data[int'(owner)*DATA_W +: DATA_W];
  assign sel_addr = req_addr[int'(owner)*ADDR_W +: ADDR_W];
  assign sel_sop  = req_sop[owner];
  assign sel_eop  = req_eop[owner];

  // Round-robin scan starting just after the previous winner.
  always_comb begin
    next_win = last_winner;
    scan_idx = last_winner;
    found    = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = IDX_W'((int'(last_winner) + k) % N_REQ);
      if (!found && req_valid[scan_idx]) begin
        next_win = scan_idx;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      owner       <= '0;
      last_winner <= IDX_W'(N_REQ - 1);
      beat_cnt    <= '0;
      grant       <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      tx_addr     <= '0;
      tx_sop      <= 1'b0;
      tx_eop      <= 1'b0;
      pkt_count   <= '0;
      sop_err     <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      if (load) begin
        tx_valid <= beat_acc;
        if (beat_acc) begin
          tx_data <= sel_data;
          tx_addr <= sel_addr;
          tx_sop  <= sel_sop;
          tx_eop  <= sel_eop;
        end
      end

      if (tx_valid & tx_ready & tx_eop)
        pkt_count <= pkt_count + 16'd1;

      case (state)
        ST_IDLE: begin
          if (found) begin
            grant    <= N_REQ'(1) << next_win;
            owner    <= next_win;
            beat_cnt <= '0;
            state    <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (beat_acc) begin
            if ((beat_cnt == '0) && !sel_sop)
              sop_err <= 1'b1;
            // beat_cnt still holds the pre-increment count, so this is beat MAX_BEATS+1
            if (beat_cnt == CNT_W'(MAX_BEATS))
              len_err <= 1'b1;
            if (beat_cnt != CNT_W'(MAX_BEATS + 1))
              beat_cnt <= beat_cnt + 1'b1;
            if (sel_eop) begin
              last_winner <= owner;
              grant       <= '0;
              state       <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_tx_arbiter.sv
// Scoreboard bench for stream_tx_arbiter: per-requester source queues feed the DUT,
// expected tx beats and grant order are queued by hand and checked by a monitor.
module tb_stream_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 256;
  localparam int AW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          sop;
    logic          eop;
  } beat_t;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_sop = '0;
  logic [N-1:0]    req_eop = '0;
  logic            tx_valid;
  logic            tx_ready = 1'b1;
  logic [DW-1:0]   tx_data;
  logic [AW-1:0]   tx_addr;
  logic            tx_sop;
  logic            tx_eop;
  logic [N-1:0]    grant;
  logic [15:0]     pkt_count;
  logic            sop_err;
  logic            len_err;

  stream_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .MAX_BEATS(64)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_addr(req_addr), .req_sop(req_sop), .req_eop(req_eop),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_addr(tx_addr), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .grant(grant), .pkt_count(pkt_count), .sop_err(sop_err), .len_err(len_err)
  );

  always #5 clk = ~clk;

  beat_t src_q[N][$];
  beat_t exp_q[$];
  int    gexp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    n_in  = 0;
  int    n_out = 0;

  logic [N-1:0] fire = '0;
  logic         fired_any = 1'b0;
  beat_t        fired_beat;
  logic         stalled = 1'b0;
  beat_t        held;
  logic [N-1:0] prev_grant = '0;

  task automatic check(string name, logic [263:0] act, logic [263:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(int r, int p, int b, int n, bit sop_ok);
    beat_t       bt;
    logic [31:0] w;
    w       = 32'hA500_0000 | 32'(r << 20) | 32'(p << 8) | 32'(b);
    bt.data = {8{w}};
    bt.addr = AW'(r + p);
    bt.sop  = sop_ok && (b == 0);
    bt.eop  = (b == n - 1);
    return bt;
  endfunction

  task automatic send(int r, int p, int n, bit sop_ok = 1'b1);
    for (int b = 0; b < n; b++) src_q[r].push_back(mk(r, p, b, n, sop_ok));
  endtask

  task automatic expect_pkt(int r, int p, int n, bit sop_ok = 1'b1);
    for (int b = 0; b < n; b++) exp_q.push_back(mk(r, p, b, n, sop_ok));
    gexp_q.push_back(r);
  endtask

  function automatic bit busy();
    bit any;
    any = (exp_q.size() != 0);
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) any = 1'b1;
    return any;
  endfunction

  task automatic wait_done(int budget);
    int c = 0;
    while (busy() && c < budget) begin
      @(negedge clk); #2; c++;
    end
    check("drain_timeout", {263'd0, busy()}, 264'd0);
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic wait_in(int target, int budget);
    int c = 0;
    while (n_in < target && c < budget) begin
      @(negedge clk); #2; c++;
    end
    check("wait_in_timeout", {263'd0, (n_in >= target)}, 264'd1);
  endtask

  task automatic wait_out(int target, int budget);
    int c = 0;
    while (n_out < target && c < budget) begin
      @(negedge clk); #2; c++;
    end
    check("wait_out_timeout", {263'd0, (n_out >= target)}, 264'd1);
  endtask

  // Requester drivers plus tx monitor, in one process so their ordering is fixed.
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        fire = '0; fired_any = 1'b0; stalled = 1'b0; prev_grant = '0;
        req_valid = '0;
        continue;
      end
      if (fired_any) begin
        check("latency_valid", {263'd0, tx_valid}, 264'd1);
        check("latency_data", {8'd0, tx_data}, {8'd0, fired_beat.data});
      end
      if (stalled) check("stall_hold", {2'd0, tx_data, tx_addr, tx_sop, tx_eop}, {2'd0, held});
      for (int i = 0; i < N; i++)
        if (fire[i]) begin
          void'(src_q[i].pop_front());
          n_in++;
        end
      if (grant !== prev_grant && grant != '0) begin
        check("grant_onehot", {263'd0, ($countones(grant) == 1)}, 264'd1);
        if (gexp_q.size() == 0) check("grant_unexpected", {260'd0, grant}, 264'd0);
        else check("grant_order", {260'd0, grant}, 264'(1) << gexp_q.pop_front());
      end
      prev_grant = grant;
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]            = 1'b1;
          req_data[i*DW +: DW]    = src_q[i][0].data;
          req_addr[i*AW +: AW]    = src_q[i][0].addr;
          req_sop[i]              = src_q[i][0].sop;
          req_eop[i]              = src_q[i][0].eop;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      #1;
      fire      = req_valid & req_ready;
      fired_any = |fire;
      for (int i = 0; i < N; i++) if (fire[i]) fired_beat = src_q[i][0];
      stalled = tx_valid && !tx_ready;
      held    = {tx_data, tx_addr, tx_sop, tx_eop};
      if (stalled) check("stall_req_ready", {260'd0, req_ready}, 264'd0);
      if (tx_valid && tx_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("tx_unexpected", 264'd1, 264'd0);
        else check("tx_beat", {2'd0, tx_data, tx_addr, tx_sop, tx_eop}, {2'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(string tag);
    check({tag, "_tx_valid"}, {263'd0, tx_valid}, 264'd0);
    check({tag, "_grant"}, {260'd0, grant}, 264'd0);
    check({tag, "_req_ready"}, {260'd0, req_ready}, 264'd0);
    check({tag, "_pkt_count"}, {248'd0, pkt_count}, 264'd0);
    check({tag, "_errs"}, {262'd0, sop_err, len_err}, 264'd0);
    check({tag, "_tx_data"}, {8'd0, tx_data}, 264'd0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    resetn = 1'b1;

    // 1: single requester, 3-beat packet
    @(negedge clk); #2;
    send(0, 0, 3); expect_pkt(0, 0, 3);
    wait_done(50);
    check("t1_pkt_count", {248'd0, pkt_count}, 264'd1);
    check("t1_grant_idle", {260'd0, grant}, 264'd0);

    // 2: fairness from reset, owner order 0,1,2,3,0
    resetn = 1'b0;
    repeat (2) @(negedge clk); #2;
    resetn = 1'b1;
    @(negedge clk); #2;
    send(0, 1, 2); send(0, 2, 2); send(1, 1, 2); send(2, 1, 2); send(3, 1, 2);
    expect_pkt(0, 1, 2); expect_pkt(1, 1, 2); expect_pkt(2, 1, 2);
    expect_pkt(3, 1, 2); expect_pkt(0, 2, 2);
    wait_done(100);
    check("t2_pkt_count", {248'd0, pkt_count}, 264'd5);

    // 3: backpressure for 5 cycles mid-packet
    base = n_out;
    send(2, 3, 4); expect_pkt(2, 3, 4);
    wait_out(base + 2, 50);
    @(negedge clk);
    tx_ready = 1'b0;
    repeat (5) @(negedge clk);
    tx_ready = 1'b1;
    #2;
    wait_done(50);
    check("t3_beats_out", 264'(n_out - base), 264'd4);
    check("t3_pkt_count", {248'd0, pkt_count}, 264'd6);

    // 4: missing sop, then a 65-beat packet
    send(1, 4, 2, 1'b0); expect_pkt(1, 4, 2, 1'b0);
    wait_done(50);
    check("t4_sop_err", {263'd0, sop_err}, 264'd1);
    check("t4_len_err_clear", {263'd0, len_err}, 264'd0);
    base = n_in;
    send(3, 5, 65); expect_pkt(3, 5, 65);
    wait_in(base + 64, 200);
    check("t4_len_err_beat64", {263'd0, len_err}, 264'd0);
    wait_in(base + 65, 20);
    check("t4_len_err_beat65", {263'd0, len_err}, 264'd1);
    wait_done(50);
    check("t4_pkt_count", {248'd0, pkt_count}, 264'd8);
    check("t4_sop_err_sticky", {263'd0, sop_err}, 264'd1);

    // 5: reset during beat 2 of 4, then req1 must win over req3
    base = n_in;
    send(0, 6, 4); expect_pkt(0, 6, 4);
    wait_in(base + 1, 50);
    resetn = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    gexp_q.delete();
    repeat (2) @(negedge clk); #2;
    resetn = 1'b1;
    @(negedge clk); #2;
    send(3, 7, 1); send(1, 7, 2);
    expect_pkt(1, 7, 2); expect_pkt(3, 7, 1);
    wait_done(50);
    check("t5_pkt_count", {248'd0, pkt_count}, 264'd2);

    // 6: counter wrap with single-beat packets
    force dut.pkt_count = 16'hFFFF;
    #1;
    release dut.pkt_count;
    @(negedge clk); #2;
    send(2, 8, 1); expect_pkt(2, 8, 1);
    wait_done(50);
    check("t6_wrap", {248'd0, pkt_count}, 264'd0);
    send(1, 9, 1); expect_pkt(1, 9, 1);
    wait_done(50);
    check("t6_after_wrap", {248'd0, pkt_count}, 264'd1);
    check("t6_scoreboard_empty", 264'(exp_q.size() + gexp_q.size()), 264'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
